// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full threshold and overflow/underflow reporting.
// Optional feature macro: FIFO_STICKY_ERR_EN
//   defined   -> overflow/underflow latch on first event until reset
//   undefined -> overflow/underflow pulse for one cycle per rejected request
module sync_fifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AF_MARGIN = 4,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_acc, rd_acc;

  // Accept/reject decisions, next pointers, occupancy and status flags
  always_comb begin
    wr_acc  = wr_en && !full_q;
    rd_acc  = rd_en && !empty_q;
    wptr_d  = wptr_q + CW'(wr_acc);
    rptr_d  = rptr_q + CW'(rd_acc);
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Full: same slot, opposite lap; empty: identical pointers
    full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    empty_d = (wptr_d == rptr_d);
    af_d    = (count_d >= CW'(DEPTH - AF_MARGIN));
`ifdef FIFO_STICKY_ERR_EN
    ovf_d   = ovf_q | (wr_en && full_q);
    unf_d   = unf_q | (rd_en && empty_q);
`else
    ovf_d   = wr_en && full_q;
    unf_d   = rd_en && empty_q;
`endif
  end

  // Storage write; contents survive reset, but reset blocks a same-cycle write
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Control state and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem[rptr_q[AW-1:0]];
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table for status flags plus a data scoreboard
// for read ordering; DEPTH=8, AF_MARGIN=2.
module tb_sync_fifo_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFM   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       wr;
    bit       rd;
    bit [7:0] d;
    bit [3:0] cnt;
    bit       full;
    bit       af;
    bit       empty;
    bit       ovf;   // pulse-build expectation
    bit       unf;   // pulse-build expectation
  } vec_t;

  vec_t     vecs[$];
  bit [7:0] model[$];   // reference FIFO contents
  bit [7:0] exp_q[$];   // scoreboard: data expected on rd_valid
  int       n_vec  = 0;
  int       n_fail = 0;

  function automatic void add(input bit rst, input bit wr, input bit rd, input int d,
                              input int c, input bit f, input bit af, input bit e,
                              input bit o, input bit u);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.d = 8'(d); v.cnt = 4'(c);
    v.full = f; v.af = af; v.empty = e; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t     v;
    bit       wa, ra, exp_valid, st_o, st_u, eo, eu;
    bit [7:0] last_rd, exp_d;
    int       c;

    // Reset and idle
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) add(0, 1, 0, i, i, i == 8, i >= 6, 0, 0, 0);
    // Overflow attempt with 0xAA, then pulse drops
    add(0, 1, 0, 'hAA, 8, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
    // Drain 8
    for (int i = 1; i <= 8; i++) begin
      c = 8 - i;
      add(0, 0, 1, 0, c, 0, c >= 6, c == 0, 0, 0);
    end
    // Underflow, then pulse drops
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Both while empty: write only, underflow
    add(0, 1, 1, 'h10, 1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) add(0, 1, 0, 'h10 + i, 1 + i, 0, 0, 0, 0, 0);
    // Both at count 4 for 20 cycles: pointers wrap, count steady
    for (int i = 0; i < 20; i++) add(0, 1, 1, 'h20 + i, 4, 0, 0, 0, 0, 0);
    // Fill to full
    for (int i = 0; i < 4; i++) begin
      c = 5 + i;
      add(0, 1, 0, 'h40 + i, c, c == 8, c >= 6, 0, 0, 0);
    end
    // Both while full: read only, overflow
    add(0, 1, 1, 'hBB, 7, 0, 1, 0, 1, 0);
    add(0, 1, 0, 'h44, 8, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      c = 8 - i;
      add(0, 0, 1, 0, c, 0, c >= 6, 0, 0, 0);
    end
    // Reset at count 5 with rd_en high
    add(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 'h55, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    // Reset beats a same-cycle write
    add(0, 1, 0, 'h66, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 'h77, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    last_rd = 8'h00; st_o = 1'b0; st_u = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      v       = vecs[k];
      reset   = v.rst;
      wr_en   = v.wr;
      rd_en   = v.rd;
      wr_data = v.d;
      if (v.rst) begin
        model.delete();
        exp_q.delete();
        last_rd   = 8'h00;
        st_o      = 1'b0;
        st_u      = 1'b0;
        exp_valid = 1'b0;
      end else begin
        wa = v.wr && (model.size() < DEPTH);
        ra = v.rd && (model.size() > 0);
        if (ra) exp_q.push_back(model.pop_front());
        if (wa) model.push_back(v.d);
        exp_valid = ra;
        st_o = st_o | v.ovf;
        st_u = st_u | v.unf;
      end
`ifdef FIFO_STICKY_ERR_EN
      eo = st_o;
      eu = st_u;
`else
      eo = v.ovf;
      eu = v.unf;
`endif
      @(posedge clk); #1;

      check("status{cnt,full,af,empty,ovf,unf,vld}", k,
            int'({count, full, almost_full, empty, overflow, underflow, rd_valid}),
            int'({v.cnt, v.full, v.af, v.empty, eo, eu, exp_valid}));

      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", k, 1, 0);
        end else begin
          exp_d   = exp_q.pop_front();
          check("rd_data", k, int'(rd_data), int'(exp_d));
          last_rd = exp_d;
        end
      end else begin
        check("rd_data_hold", k, int'(rd_data), int'(last_rd));
      end
    end

    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("scoreboard_drained", vecs.size(), exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
